// File: rtl/compn_pkg.sv
// Shared types and constants for the digit-serial comparator.
package compn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result vectors are ordered {gt, eq, lt}.
  localparam logic [2:0] RES_LT = 3'b001;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_GT = 3'b100;

endpackage

// File: rtl/compn_digit.sv
// Combinational unsigned compare of one DIGIT-wide slice.
module compn_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             gt_o,
  output logic             lt_o
);

  assign gt_o = (a_i > b_i);
  assign lt_o = (a_i < b_i);

endmodule

// File: rtl/compn_serial.sv
// MSB-first digit-serial magnitude comparator with early exit and start/done handshake.
// Optional signed mode is enabled by defining COMPN_SIGNED_EN.
module compn_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sgn,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);
  import compn_pkg::*;

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic             sgn_q, sgn_d;
  logic [2:0]       res_q, res_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] msbMask;
  logic [DIGIT-1:0] digA, digB;
  logic             digGt, digLt;

`ifdef COMPN_SIGNED_EN
  // Flipping the sign bit on the first digit maps two's complement onto offset binary.
  always_comb begin
    msbMask = '0;
    msbMask[DIGIT-1] = sgn_q && (cnt_q == '0);
  end
`else
  logic unusedSgn;
  assign msbMask   = '0;
  assign unusedSgn = sgn_q;
`endif

  assign digA = aSh_q[WIDTH-1 -: DIGIT] ^ msbMask;
  assign digB = bSh_q[WIDTH-1 -: DIGIT] ^ msbMask;

  compn_digit #(.DIGIT(DIGIT)) u_digit (
    .a_i  (digA),
    .b_i  (digB),
    .gt_o (digGt),
    .lt_o (digLt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      aSh_q   <= '0;
      bSh_q   <= '0;
      sgn_q   <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      sgn_q   <= sgn_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    sgn_d   = sgn_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          aSh_d   = a_in;
          bSh_d   = b_in;
          sgn_d   = sgn;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (digGt || digLt) begin
          res_d   = digGt ? RES_GT : RES_LT;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == LAST) begin
          res_d   = RES_EQ;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          aSh_d = aSh_q << DIGIT;
          bSh_d = bSh_q << DIGIT;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign gt   = res_q[2];
  assign eq   = res_q[1];
  assign lt   = res_q[0];

endmodule
